// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage MIPS core
//
// Purpose:
//   Sits beside the ID stage and sequences the PC, IF/ID and ID/EX registers.
//   It detects load-use hazards and branch-operand hazards that the ID-stage
//   ALUResult forwarding path cannot cover. It holds the front of the pipe
//   and inserts bubbles into ID/EX for the required number of cycles. It also
//   raises IF_Flush for taken branches that are resolved in ID.
//
// Hazard classes (register 0 never matches):
//   H2  : beq in ID, load in EX writing a source   -> 2 held cycles
//   H1a : non-branch in ID, load in EX writing src -> 1 held cycle
//   H1b : beq in ID, load in MEM writing a source  -> 1 held cycle
//   Non-load EX writers are covered by ID forwarding and never stall.
//   H2 takes priority over H1a/H1b.
//
// Optional feature:
//   Define HAZARD_PERF_CNT_EN to add the saturating StallCount and FlushCount
//   outputs. The default build leaves them out.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   IFID_RegisterRs/Rt               source registers of the instruction in ID
//   Branch, Iguales                  beq in ID, ID-stage equality result
//   IDEX_MemRead/RegWrite/RegisterRd  load / write / destination of EX instr
//   EXMEM_MemRead/RegisterRd         load / destination of MEM instr
//   PCWrite, IFIDWrite               PC and IF/ID enables
//   CtrlBubble                       zero the ID/EX control signals
//   IF_Flush                         clear IF/ID for a taken branch
//   Stalling                         registered, high while in STALL
//   StallCount, FlushCount           (HAZARD_PERF_CNT_EN only) counters

module hazard_ctrl #(
  parameter int REG_DIR_WIDTH = 3,
  parameter int OP_WIDTH      = 6,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_DIR_WIDTH-1:0] IFID_RegisterRs,
  input  logic [REG_DIR_WIDTH-1:0] IFID_RegisterRt,
  input  logic                     Branch,
  input  logic                     Iguales,
  input  logic                     IDEX_MemRead,
  input  logic                     IDEX_RegWrite,
  input  logic [REG_DIR_WIDTH-1:0] IDEX_RegisterRd,
  input  logic                     EXMEM_MemRead,
  input  logic [REG_DIR_WIDTH-1:0] EXMEM_RegisterRd,
  output logic                     PCWrite,
  output logic                     IFIDWrite,
  output logic                     CtrlBubble,
  output logic                     IF_Flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]     StallCount,
  output logic [CNT_WIDTH-1:0]     FlushCount,
`endif
  output logic                     Stalling
);

  // Degenerate widths are meaningless; an empty named block keeps the
  // parameters referenced in every build configuration.
  if (OP_WIDTH < 1 || REG_DIR_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_width
  end

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] remaining;

  logic idex_match;
  logic exmem_match;
  logic h2;
  logic h1a;
  logic h1b;
  logic hazard;

  // An address match needs a non-zero destination equal to Rs or Rt.
  assign idex_match  = (IDEX_RegisterRd != '0) &&
                       ((IDEX_RegisterRd == IFID_RegisterRs) ||
                        (IDEX_RegisterRd == IFID_RegisterRt));
  assign exmem_match = (EXMEM_RegisterRd != '0) &&
                       ((EXMEM_RegisterRd == IFID_RegisterRs) ||
                        (EXMEM_RegisterRd == IFID_RegisterRt));

  // IDEX_RegWrite alone never stalls: the ID forwarding path covers ALU results.
  assign h2     =  Branch & IDEX_MemRead  & idex_match;
  assign h1a    = ~Branch & IDEX_MemRead  & idex_match;
  assign h1b    =  Branch & EXMEM_MemRead & exmem_match;
  assign hazard = (state == RUN) & (h2 | h1a | h1b);

  // The first held cycle of any hazard is produced combinationally in RUN.
  // Only the second cycle of H2 needs the STALL state. A pending taken branch
  // raises IF_Flush only in a hazard-free RUN cycle, so a flush is never lost
  // or duplicated across a stall.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    CtrlBubble = 1'b0;
    IF_Flush   = Branch & Iguales;
    if (rst || state == STALL || hazard) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      CtrlBubble = 1'b1;
      IF_Flush   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      remaining <= 2'd0;
      Stalling  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (h2) begin
            state     <= STALL;
            remaining <= 2'd1;
            Stalling  <= 1'b1;
          end else begin
            Stalling  <= 1'b0;
          end
        end
        STALL: begin
          // Leave once the decremented count reaches zero. The <= guard also
          // recovers from a zero count instead of wrapping.
          remaining <= (remaining == 2'd0) ? 2'd0 : remaining - 2'd1;
          if (remaining <= 2'd1) begin
            state    <= RUN;
            Stalling <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          remaining <= 2'd0;
          Stalling  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && StallCount != '1)
        StallCount <= StallCount + 1'b1;
      if (IF_Flush && FlushCount != '1)
        FlushCount <= FlushCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  localparam int W  = 3;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] rs, rt, idex_rd, exmem_rd;
  logic         br, eq, idex_mr, idex_rw, exmem_mr;
  logic         pc_write, ifid_write, bubble, flush, stalling;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_count, flush_count;
  int            exp_stall_cnt = 0;
  int            exp_flush_cnt = 0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_DIR_WIDTH(W), .OP_WIDTH(6), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .IFID_RegisterRs (rs),
    .IFID_RegisterRt (rt),
    .Branch          (br),
    .Iguales         (eq),
    .IDEX_MemRead    (idex_mr),
    .IDEX_RegWrite   (idex_rw),
    .IDEX_RegisterRd (idex_rd),
    .EXMEM_MemRead   (exmem_mr),
    .EXMEM_RegisterRd(exmem_rd),
    .PCWrite         (pc_write),
    .IFIDWrite       (ifid_write),
    .CtrlBubble      (bubble),
    .IF_Flush        (flush),
`ifdef HAZARD_PERF_CNT_EN
    .StallCount      (stall_count),
    .FlushCount      (flush_count),
`endif
    .Stalling        (stalling)
  );

  // exp = {PCWrite, IFIDWrite, CtrlBubble, IF_Flush, Stalling}
  typedef struct {
    string        name;
    logic         rst;
    logic [W-1:0] rs, rt;
    logic         br, eq, idex_mr, idex_rw;
    logic [W-1:0] idex_rd;
    logic         exmem_mr;
    logic [W-1:0] exmem_rd;
    logic [4:0]   exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, logic r, logic [W-1:0] s, logic [W-1:0] t,
                              logic b, logic e, logic imr, logic irw, logic [W-1:0] ird,
                              logic emr, logic [W-1:0] erd, logic [4:0] x);
    vec_t v;
    v.name = n; v.rst = r; v.rs = s; v.rt = t; v.br = b; v.eq = e;
    v.idex_mr = imr; v.idex_rw = irw; v.idex_rd = ird;
    v.exmem_mr = emr; v.exmem_rd = erd; v.exp = x;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge, queue the expected
  // outputs, then pop and compare at the falling edge.
  task automatic apply(input vec_t v);
    sb_t e, got;
    logic [4:0] act;
    @(posedge clk);
    #1;
    rst = v.rst; rs = v.rs; rt = v.rt; br = v.br; eq = v.eq;
    idex_mr = v.idex_mr; idex_rw = v.idex_rw; idex_rd = v.idex_rd;
    exmem_mr = v.exmem_mr; exmem_rd = v.exmem_rd;
    e.name = v.name;
    e.exp  = v.exp;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    act = {pc_write, ifid_write, bubble, flush, stalling};
    checks++;
    if (act !== got.exp) begin
      errors++;
      $display("FAIL %s: {pc,ifid,bubble,flush,stalling} got %b expected %b",
               got.name, act, got.exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_count !== CW'(exp_stall_cnt) || flush_count !== CW'(exp_flush_cnt)) begin
      errors++;
      $display("FAIL %s counters: stall %0d flush %0d expected stall %0d flush %0d",
               got.name, stall_count, flush_count, exp_stall_cnt, exp_flush_cnt);
    end
    // The counters update at the next edge from this cycle's expected outputs.
    if (v.rst) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (!got.exp[4]) exp_stall_cnt++;
      if (got.exp[1])  exp_flush_cnt++;
    end
`endif
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; br = 1'b0; eq = 1'b0;
    idex_mr = 1'b0; idex_rw = 1'b0; idex_rd = '0; exmem_mr = 1'b0; exmem_rd = '0;
`ifdef HAZARD_PERF_CNT_EN
    // Power-up counter values are unknown until the first reset edge.
    @(posedge clk);
`endif

    //            name          rst rs rt br eq imr irw ird emr erd  exp
    vecs.push_back(mk("rst0",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
    vecs.push_back(mk("rst1",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
    vecs.push_back(mk("release",    0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    vecs.push_back(mk("h1a_rs",     0, 3, 1, 0, 0, 1, 1, 3, 0, 0, 5'b00100));
    vecs.push_back(mk("h1a_clear",  0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    vecs.push_back(mk("rd0_nostall",0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 5'b11000));
    vecs.push_back(mk("h1a_rt",     0, 1, 2, 0, 0, 1, 1, 2, 0, 0, 5'b00100));
    vecs.push_back(mk("h2_first",   0, 1, 5, 1, 1, 1, 1, 5, 0, 0, 5'b00100));
    vecs.push_back(mk("h2_stall",   0, 1, 5, 1, 1, 1, 1, 5, 1, 5, 5'b00101));
    vecs.push_back(mk("h2_flush",   0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 5'b11010));
    vecs.push_back(mk("fwd_noflush",0, 4, 1, 1, 0, 0, 1, 4, 0, 0, 5'b11000));
    vecs.push_back(mk("fwd_flush",  0, 4, 1, 1, 1, 0, 1, 4, 0, 0, 5'b11010));
    vecs.push_back(mk("h1b",        0, 6, 1, 1, 1, 0, 0, 0, 1, 6, 5'b00100));
    vecs.push_back(mk("h1b_flush",  0, 6, 1, 1, 1, 0, 0, 0, 0, 0, 5'b11010));
    vecs.push_back(mk("exmem_nobr", 0, 6, 1, 0, 0, 0, 0, 0, 1, 6, 5'b11000));
    vecs.push_back(mk("h2_rd0",     0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 5'b11000));
    vecs.push_back(mk("prio_h2",    0, 5, 1, 1, 0, 1, 0, 5, 1, 5, 5'b00100));
    vecs.push_back(mk("prio_stall", 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00101));
    vecs.push_back(mk("prio_done",  0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11000));

    foreach (vecs[i]) apply(vecs[i]);

    // Back-to-back: H2, its STALL cycle, then a fresh H1b with no gap cycle.
    apply(mk("b2b_h2",    0, 2, 5, 1, 1, 1, 0, 5, 0, 0, 5'b00100));
    apply(mk("b2b_stall", 0, 2, 5, 1, 1, 1, 0, 5, 0, 0, 5'b00101));
    apply(mk("b2b_h1b",   0, 2, 5, 1, 1, 0, 0, 0, 1, 5, 5'b00100));
    apply(mk("b2b_flush", 0, 2, 5, 1, 1, 0, 0, 0, 0, 0, 5'b11010));
    apply(mk("b2b_idle",  0, 2, 5, 0, 0, 0, 0, 0, 0, 0, 5'b11000));

    // Reset during the STALL cycle of H2 aborts it; the next cycle is RUN.
    apply(mk("rst_h2",    0, 1, 7, 1, 1, 1, 0, 7, 0, 0, 5'b00100));
    apply(mk("rst_in_st", 1, 1, 7, 1, 1, 1, 0, 7, 0, 0, 5'b00101));
    apply(mk("rst_after", 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    apply(mk("rst_flush", 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 5'b11010));
    apply(mk("rst_idle",  0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 5'b11000));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
